// File: rtl/kb_event_decoder.sv
// kb_event_decoder: PS/2 scan-code decoder (E0/F0 prefixes) feeding a 2^W_SIZE-entry event FIFO
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   scan_done_tick      one-cycle pulse, scan_out holds a new byte
//   scan_out[7:0]       received scan byte
//   rd                  pop head entry (ignored when empty)
//   clr_ovf             clears the sticky overflow flag
//   dout[9:0]           head entry {ext, brk, code}, 0 while empty
//   empty, full         FIFO status
//   got_code_tick       one-cycle pulse per event written into the FIFO
//   overflow            sticky: an event was dropped because the FIFO was full
// Macro KB_MAKE_EVENTS_EN: when defined, make events are queued as well as break events.
module kb_event_decoder #(
    parameter int W_SIZE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_out,
    input  logic       rd,
    input  logic       clr_ovf,
    output logic [9:0] dout,
    output logic       empty,
    output logic       full,
    output logic       got_code_tick,
    output logic       overflow
);
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] BRK_CODE = 8'hF0;
`ifdef KB_MAKE_EVENTS_EN
    localparam bit MAKE_EN = 1'b1;
`else
    localparam bit MAKE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t            state, state_next;
    logic [9:0]        mem [2**W_SIZE];
    logic [W_SIZE:0]   wr_ptr, rd_ptr;
    logic              prefix, ext_state, brk_state, ev, wr_en, rd_en, drop;
    logic [9:0]        ev_data;

    always_comb begin
        prefix     = scan_out == EXT_CODE || scan_out == BRK_CODE;
        ext_state  = state == EXT || state == EXT_BRK;
        brk_state  = state == BRK || state == EXT_BRK;
        ev         = scan_done_tick && !prefix && (brk_state || MAKE_EN);
        ev_data    = {ext_state, brk_state, scan_out};
        empty      = wr_ptr == rd_ptr;
        full       = wr_ptr == {~rd_ptr[W_SIZE], rd_ptr[W_SIZE-1:0]};
        // a pop frees the slot in the same cycle, so a full FIFO still accepts when rd is high
        wr_en      = ev && (!full || rd);
        rd_en      = rd && !empty;
        drop       = ev && full && !rd;
        dout       = empty ? '0 : mem[rd_ptr[W_SIZE-1:0]];
        state_next = !scan_done_tick ? state :
                     !prefix ? IDLE :
                     state == IDLE ? (scan_out == EXT_CODE ? EXT : BRK) :
                     (state == EXT && scan_out == BRK_CODE) ? EXT_BRK : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            got_code_tick <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_next;
            wr_ptr        <= wr_en ? wr_ptr + (W_SIZE+1)'(1) : wr_ptr;
            rd_ptr        <= rd_en ? rd_ptr + (W_SIZE+1)'(1) : rd_ptr;
            got_code_tick <= wr_en;
            overflow      <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr[W_SIZE-1:0]] <= ev_data;
endmodule
